// File: rtl/gpu_pkg.sv
// Shared constants for the tensor operand path: core FSM encodings, tile geometry
// and the operand loader state encoding.
package gpu_pkg;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;

  localparam int TENSOR_N  = 4;
  localparam int ELEM_BITS = 8;
  localparam int ROW_BITS  = TENSOR_N * ELEM_BITS;
  localparam int TILE_BITS = TENSOR_N * ROW_BITS;

  typedef enum logic [1:0] {
    LD_IDLE = 2'b00,
    LD_REQ  = 2'b01,
    LD_WAIT = 2'b10,
    LD_DONE = 2'b11
  } loader_state_e;

endpackage

// File: rtl/tensor_row_scatter.sv
// Places one fetched B word into the column-packed rt tile: returns the byte mask
// and aligned data for either a row-major (transpose) or column-major source word.
module tensor_row_scatter
  import gpu_pkg::*;
(
  input  logic [ROW_BITS-1:0]  i_word,
  input  logic [1:0]           i_row,
  input  logic                 i_transpose,
  output logic [TILE_BITS-1:0] o_mask,
  output logic [TILE_BITS-1:0] o_data
);

  always_comb begin
    o_mask = '0;
    o_data = '0;
    if (i_transpose) begin
      // word is B row r: element k lands in column k at position r
      for (int k = 0; k < TENSOR_N; k++) begin
        o_mask[ELEM_BITS*(k*TENSOR_N + int'(i_row)) +: ELEM_BITS] = '1;
        o_data[ELEM_BITS*(k*TENSOR_N + int'(i_row)) +: ELEM_BITS] = i_word[ELEM_BITS*k +: ELEM_BITS];
      end
    end else begin
      o_mask[ROW_BITS*i_row +: ROW_BITS] = '1;
      o_data[ROW_BITS*i_row +: ROW_BITS] = i_word;
    end
  end

endmodule

// File: rtl/tensor_operand_loader.sv
// Fetches the 4x4 int8 A and B tiles over the LSU read handshake and packs them into rs/rt.
// IDLE: wait for tensor load | REQ: issue read | WAIT: await ready | DONE: hold until EXECUTE
module tensor_operand_loader
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_tensor_ld,
  input  logic                 decoded_b_transpose,
  input  logic [ADDR_BITS-1:0] base_a,
  input  logic [ADDR_BITS-1:0] base_b,
  input  logic [ADDR_BITS-1:0] stride,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic [TILE_BITS-1:0] rs,
  output logic [TILE_BITS-1:0] rt,
  output logic [1:0]           loader_state
);

  loader_state_e        r_state;
  logic [2:0]           r_beat;
  logic [ADDR_BITS-1:0] r_base_a;
  logic [ADDR_BITS-1:0] r_base_b;
  logic [ADDR_BITS-1:0] r_stride;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_valid;
  logic                 r_b_transpose;
  logic [TILE_BITS-1:0] r_rs;
  logic [TILE_BITS-1:0] r_rt;

  logic [ADDR_BITS-1:0] w_offset;
  logic [ADDR_BITS-1:0] w_addr;
  logic [TILE_BITS-1:0] w_rt_mask;
  logic [TILE_BITS-1:0] w_rt_data;

  // beats 0..3 walk A, 4..7 walk B; wrap-around past 2^ADDR_BITS is intentional
  assign w_offset = ADDR_BITS'(r_beat[1:0]) * r_stride;
  assign w_addr   = (r_beat[2] ? r_base_b : r_base_a) + w_offset;

  tensor_row_scatter u_scatter (
    .i_word      (mem_read_data[ROW_BITS-1:0]),
    .i_row       (r_beat[1:0]),
    .i_transpose (r_b_transpose),
    .o_mask      (w_rt_mask),
    .o_data      (w_rt_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= LD_IDLE;
      r_beat        <= '0;
      r_base_a      <= '0;
      r_base_b      <= '0;
      r_stride      <= '0;
      r_addr        <= '0;
      r_valid       <= 1'b0;
      r_b_transpose <= 1'b0;
      r_rs          <= '0;
      r_rt          <= '0;
    end else if (enable) begin
      case (r_state)
        LD_IDLE: begin
          if (core_state == CORE_REQUEST && decoded_tensor_ld) begin
            r_base_a      <= base_a;
            r_base_b      <= base_b;
            r_stride      <= stride;
            r_b_transpose <= decoded_b_transpose;
            r_beat        <= '0;
            r_state       <= LD_REQ;
          end
        end
        LD_REQ: begin
          r_valid <= 1'b1;
          r_addr  <= w_addr;
          r_state <= LD_WAIT;
        end
        LD_WAIT: begin
          if (mem_read_ready && r_valid) begin
            r_valid <= 1'b0;
            if (!r_beat[2]) begin
              r_rs[ROW_BITS*r_beat[1:0] +: ROW_BITS] <= mem_read_data[ROW_BITS-1:0];
            end else begin
              r_rt <= (r_rt & ~w_rt_mask) | (w_rt_data & w_rt_mask);
            end
            r_beat  <= r_beat + 3'd1;
            r_state <= (r_beat == 3'd7) ? LD_DONE : LD_REQ;
          end
        end
        LD_DONE: begin
          if (core_state == CORE_EXECUTE) begin
            r_state <= LD_IDLE;
          end
        end
        default: r_state <= LD_IDLE;
      endcase
    end
  end

  assign mem_read_valid   = r_valid;
  assign mem_read_address = r_addr;
  assign rs               = r_rs;
  assign rt               = r_rt;
  assign loader_state     = r_state;

endmodule

// File: tb/tb_tensor_operand_loader.sv
// Scoreboard bench for tensor_operand_loader: expected addresses and packed tiles are
// queued at launch and compared when the loader issues requests or reaches DONE.
module tb_tensor_operand_loader;

  localparam logic [2:0] C_REQUEST = 3'b011;
  localparam logic [2:0] C_WAIT    = 3'b100;
  localparam logic [2:0] C_EXECUTE = 3'b101;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_WAIT = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [2:0]   core_state;
  logic         decoded_tensor_ld;
  logic         decoded_b_transpose;
  logic [7:0]   base_a;
  logic [7:0]   base_b;
  logic [7:0]   stride;
  logic         mem_read_valid;
  logic [7:0]   mem_read_address;
  logic         mem_read_ready;
  logic [31:0]  mem_read_data;
  logic [127:0] rs;
  logic [127:0] rt;
  logic [1:0]   loader_state;

  tensor_operand_loader #(.ADDR_BITS(8), .DATA_BITS(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .core_state          (core_state),
    .decoded_tensor_ld   (decoded_tensor_ld),
    .decoded_b_transpose (decoded_b_transpose),
    .base_a              (base_a),
    .base_b              (base_b),
    .stride              (stride),
    .mem_read_valid      (mem_read_valid),
    .mem_read_address    (mem_read_address),
    .mem_read_ready      (mem_read_ready),
    .mem_read_data       (mem_read_data),
    .rs                  (rs),
    .rt                  (rt),
    .loader_state        (loader_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0]  mem [256];
  logic [7:0]   addr_q [$];
  logic [127:0] rs_q [$];
  logic [127:0] rt_q [$];
  int           resp_delay = 0;
  int           wait_cnt   = 0;
  int           req_seen   = 0;
  logic         prev_valid = 1'b0;
  logic [7:0]   cur_exp_addr = '0;

  // memory responder: one-cycle ready strobe after resp_delay idle cycles
  always @(negedge clk) begin
    if (!reset || mem_read_ready || !mem_read_valid) begin
      mem_read_ready = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= resp_delay) begin
      mem_read_ready = 1'b1;
      mem_read_data  = mem[mem_read_address];
    end else begin
      wait_cnt++;
    end
  end

  // request monitor: pops the expected address on each new request, checks it holds
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_read_valid && !prev_valid) begin
        req_seen++;
        check("addr_q_nonempty", 128'(addr_q.size() != 0), 128'(1'b1));
        if (addr_q.size() != 0) begin
          cur_exp_addr = addr_q.pop_front();
          check("req_addr", 128'(mem_read_address), 128'(cur_exp_addr));
        end
      end else if (mem_read_valid) begin
        check("addr_stable", 128'(mem_read_address), 128'(cur_exp_addr));
      end
      prev_valid = mem_read_valid;
    end
  end

  task automatic reset_dut();
    reset = 1'b0;
    enable = 1'b1;
    core_state = 3'b000;
    decoded_tensor_ld = 1'b0;
    decoded_b_transpose = 1'b0;
    base_a = '0;
    base_b = '0;
    stride = '0;
    mem_read_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_expect(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] st,
                             input logic tr);
    logic [127:0] e_rs;
    logic [127:0] e_rt;
    logic [7:0]   a;
    logic [31:0]  w;
    e_rs = '0;
    e_rt = '0;
    for (int i = 0; i < 4; i++) begin
      a = ba + 8'(i) * st;
      addr_q.push_back(a);
      e_rs[32*i +: 32] = mem[a];
    end
    for (int r = 0; r < 4; r++) begin
      a = bb + 8'(r) * st;
      addr_q.push_back(a);
      w = mem[a];
      if (tr) begin
        for (int k = 0; k < 4; k++) e_rt[8*(k*4+r) +: 8] = w[8*k +: 8];
      end else begin
        e_rt[32*r +: 32] = w;
      end
    end
    rs_q.push_back(e_rs);
    rt_q.push_back(e_rt);
  endtask

  task automatic run_load(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] st,
                          input logic tr, input int dly, input bit tog);
    logic [127:0] e_rs;
    logic [127:0] e_rt;
    int c;
    int t_req;
    int t_done;
    int waits;
    resp_delay = dly;
    push_expect(ba, bb, st, tr);
    base_a = ba;
    base_b = bb;
    stride = st;
    decoded_b_transpose = tr;
    decoded_tensor_ld = 1'b1;
    core_state = C_REQUEST;
    c = 0;
    t_req = -1;
    t_done = -1;
    waits = 0;
    while (c < 400 && t_done < 0) begin
      @(negedge clk);
      c++;
      if (loader_state == S_REQ && t_req < 0) begin
        t_req = c;
        core_state = C_WAIT;
      end
      if (tog && loader_state == S_WAIT) begin
        waits++;
        if (waits == 5) begin
          enable = 1'b0;
          repeat (2) begin
            @(negedge clk);
            c++;
            check("freeze_state", 128'(loader_state), 128'(S_WAIT));
            check("freeze_valid", 128'(mem_read_valid), 128'(1'b1));
          end
          enable = 1'b1;
        end
      end
      if (loader_state == S_DONE) t_done = c;
    end
    check("done_reached", 128'(loader_state), 128'(S_DONE));
    if (dly == 0 && !tog) check("zero_wait_latency", 128'(t_done - t_req), 128'(16));
    e_rs = rs_q.pop_front();
    e_rt = rt_q.pop_front();
    check("rs_done", rs, e_rs);
    check("rt_done", rt, e_rt);
    core_state = C_EXECUTE;
    decoded_tensor_ld = 1'b0;
    @(negedge clk);
    check("handoff_idle", 128'(loader_state), 128'(S_IDLE));
    check("handoff_rs_held", rs, e_rs);
    check("handoff_rt_held", rt, e_rt);
    core_state = 3'b000;
    @(negedge clk);
    check("addr_q_drained", 128'(addr_q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int seen0;
    for (int i = 0; i < 256; i++)
      mem[i] = {8'(i + 3), 8'(i) ^ 8'h5A, 8'(i) + 8'h80, ~8'(i)};
    mem[8'h20] = 32'h04030201;
    mem[8'h21] = 32'h08070605;
    mem[8'h22] = 32'h0C0B0A09;
    mem[8'h23] = 32'h100F0E0D;
    mem_read_ready = 1'b0;

    reset_dut();
    check("rst_state", 128'(loader_state), 128'(S_IDLE));
    check("rst_valid", 128'(mem_read_valid), 128'(1'b0));
    check("rst_addr", 128'(mem_read_address), 128'(8'h00));
    check("rst_rs", rs, 128'(0));
    check("rst_rt", rt, 128'(0));

    // REQUEST without a tensor load: no transition, no traffic
    seen0 = req_seen;
    core_state = C_REQUEST;
    decoded_tensor_ld = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("noload_state", 128'(loader_state), 128'(S_IDLE));
      check("noload_valid", 128'(mem_read_valid), 128'(1'b0));
    end
    check("noload_reqs", 128'(req_seen - seen0), 128'(0));
    core_state = 3'b000;
    @(negedge clk);

    run_load(8'h10, 8'h20, 8'h01, 1'b1, 0, 1'b0);
    check("tr1_rt_word0", 128'(rt[31:0]), 128'(32'h0D090501));
    check("tr1_rt_word3", 128'(rt[127:96]), 128'(32'h100C0804));

    run_load(8'h10, 8'h20, 8'h01, 1'b0, 0, 1'b0);
    check("tr0_rt_word0", 128'(rt[31:0]), 128'(32'h04030201));

    run_load(8'h40, 8'hFE, 8'h02, 1'b1, 0, 1'b0);

    run_load(8'h10, 8'h20, 8'h01, 1'b1, 3, 1'b1);
    check("bp_rt_word0", 128'(rt[31:0]), 128'(32'h0D090501));

    // async reset in WAIT of beat 3 with A rows 0..2 already captured
    resp_delay = 3;
    push_expect(8'h10, 8'h20, 8'h01, 1'b1);
    void'(rs_q.pop_front());
    void'(rt_q.pop_front());
    seen0 = req_seen;
    base_a = 8'h10;
    base_b = 8'h20;
    stride = 8'h01;
    decoded_b_transpose = 1'b1;
    decoded_tensor_ld = 1'b1;
    core_state = C_REQUEST;
    c = 0;
    while (c < 200 && !((req_seen - seen0) == 4 && loader_state == S_WAIT)) begin
      @(negedge clk);
      c++;
      if (loader_state != S_IDLE) core_state = C_WAIT;
    end
    check("abort_at_beat3", 128'(req_seen - seen0), 128'(4));
    check("abort_partial_rs", 128'(rs[95:0]), 128'({mem[8'h12], mem[8'h11], mem[8'h10]}));
    #2;
    reset = 1'b0;
    #1;
    check("abort_state", 128'(loader_state), 128'(S_IDLE));
    check("abort_valid", 128'(mem_read_valid), 128'(1'b0));
    check("abort_rs", rs, 128'(0));
    check("abort_rt", rt, 128'(0));
    addr_q.delete();
    core_state = 3'b000;
    decoded_tensor_ld = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_load(8'h30, 8'h50, 8'h03, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
